// File: rtl/sigmoid_pkg.sv
// Shared constants for the sigmoid LUT scheduler: data format and saturation limits.
package sigmoid_pkg;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned FRAC_W = 6;
    localparam int unsigned ADDR_W = 9;

    localparam logic [DATA_W-1:0] SIG_ONE     = 12'(1 << FRAC_W);
    localparam logic [DATA_W-1:0] SIG_MAX_MAG = 12'h180;

    // Fold sign symmetry and saturation onto a positive-half LUT value.
    function automatic logic [DATA_W-1:0] sig_finish(input logic neg, input logic oor,
                                                     input logic [DATA_W-1:0] lut_val);
        if (oor) begin
            return neg ? '0 : SIG_ONE;
        end else if (neg) begin
            return SIG_ONE - lut_val;
        end
        return lut_val;
    endfunction
endpackage

// File: rtl/sigmoid_addr_calc.sv
// Maps a sign-magnitude Q5.6 operand onto a positive-half LUT address and range flag.
module sigmoid_addr_calc
    import sigmoid_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              out_of_range,
    output logic              sign_out
);
    logic [DATA_W-2:0] mag;

    assign mag          = data_in[DATA_W-2:0];
    assign sign_out     = data_in[DATA_W-1];
    assign out_of_range = {1'b0, mag} > SIG_MAX_MAG;
    // One LUT entry per LSB of magnitude; range limit 6.0 fits in ADDR_W bits.
    assign addr_out     = mag[ADDR_W-1:0];
endmodule

// File: rtl/sigmoid_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a rotating pointer.
module sigmoid_rr_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             accept
);
    logic [ID_W-1:0] ptr;
    int unsigned     idx;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        if (enable) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                idx = (int'(ptr) + k) % N_REQ;
                if (!found && req_valid[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = ID_W'(idx);
                end
            end
        end
    end

    assign accept = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            if (int'(grant_id) == N_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_id + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sigmoid_lut_sched.sv
// Shares one sync-read sigmoid LUT among N_REQ requesters with a two-stage
// (address, finish) pipeline and a stallable valid/ready response port.
module sigmoid_lut_sched
    import sigmoid_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rom_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ID_W-1:0]         rsp_id
);
    logic              stall;
    logic              accept;
    logic [ID_W-1:0]   grant_id;
    logic [DATA_W-1:0] win_data;
    logic              win_oor;
    logic              win_sign;

    logic              s1_valid;
    logic              s1_sign;
    logic              s1_oor;
    logic [ID_W-1:0]   s1_id;
    logic [DATA_W-1:0] s2_result;

    assign stall = rsp_valid & ~rsp_ready;

    sigmoid_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .enable    (~stall & ~rst),
        .req_valid (req_valid),
        .grant     (req_ready),
        .grant_id  (grant_id),
        .accept    (accept)
    );

    assign win_data = req_data[int'(grant_id)*DATA_W +: DATA_W];

    sigmoid_addr_calc u_addr (
        .data_in      (win_data),
        .addr_out     (rom_addr),
        .out_of_range (win_oor),
        .sign_out     (win_sign)
    );

    // The ROM is only read on accept, so its output stays put across a stall.
    assign rom_en = accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_oor   <= 1'b0;
            s1_id    <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sign <= win_sign;
                s1_oor  <= win_oor;
                s1_id   <= grant_id;
            end
        end
    end

    assign s2_result = sig_finish(s1_sign, s1_oor, rom_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (!stall) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_data <= s2_result;
                rsp_id   <= s1_id;
            end
        end
    end
endmodule

// File: tb/tb_sigmoid_lut_sched.sv
// Bench for sigmoid_lut_sched: directed literal checks plus randomized traffic against
// a latency-queue reference model compared every cycle.
module tb_sigmoid_lut_sched;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [47:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        rom_en;
    logic [8:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [11:0] rsp_data;
    logic [1:0]  rsp_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sigmoid_lut_sched #(
        .N_REQ (4),
        .ID_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    logic [11:0] lut [512];

    initial begin
        for (int i = 0; i < 512; i++) lut[i] = 12'(32 + i / 12);
        lut[0]   = 12'h020;
        lut[32]  = 12'h028;
        lut[192] = 12'h03F;
    end

    always @(posedge clk) if (rom_en) rom_data <= lut[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] sig_model(input logic [11:0] x);
        int mag;
        int r;
        mag = int'(x[10:0]);
        if (mag > 384) return x[11] ? 12'h000 : 12'h040;
        r = int'(lut[mag]);
        return x[11] ? 12'(64 - r) : 12'(r);
    endfunction

    // Each accepted item becomes visible after two non-stalled clock edges, in order.
    typedef struct {
        int          id;
        logic [11:0] val;
        int          d;
    } item_t;

    item_t q[$];
    int    ptr_m = 0;

    always @(negedge clk) begin
        logic       exp_rv;
        logic       stall;
        logic [3:0] g;
        int         gi;
        exp_rv = (q.size() > 0) && (q[0].d == 0);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            check("rsp_data", 32'(rsp_data), 32'(q[0].val));
            check("rsp_id", 32'(rsp_id), 32'(q[0].id));
        end
        stall = exp_rv && !rsp_ready;
        g  = '0;
        gi = -1;
        if (!rst && !stall) begin
            for (int k = 0; k < N; k++) begin
                if (gi < 0 && req_valid[(ptr_m + k) % N]) gi = (ptr_m + k) % N;
            end
        end
        if (gi >= 0) g[gi] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(g));
        check("rom_en", 32'(rom_en), 32'(|g));
        if (gi >= 0 && int'(req_data[gi*12 +: 11]) <= 384)
            check("rom_addr", 32'(rom_addr), 32'(req_data[gi*12 +: 9]));
        if (rst) begin
            q.delete();
            ptr_m = 0;
        end else if (!stall) begin
            if (exp_rv) void'(q.pop_front());
            foreach (q[i]) if (q[i].d > 0) q[i].d--;
            if (gi >= 0) begin
                q.push_back('{id: gi, val: sig_model(req_data[gi*12 +: 12]), d: 1});
                ptr_m = (gi + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int idx, input logic [11:0] x, input logic [11:0] exp_val,
                          input logic [8:0] exp_addr);
        req_valid = 4'(1 << idx);
        req_data  = '0;
        req_data[idx*12 +: 12] = x;
        @(negedge clk);
        check("single_grant", 32'(req_ready), 32'(1 << idx));
        check("single_addr", 32'(rom_addr), 32'(exp_addr));
        tick();
        req_valid = '0;
        @(negedge clk);
        check("lat_t1_quiet", 32'(rsp_valid), 32'(0));
        @(negedge clk);
        check("lat_t2_valid", 32'(rsp_valid), 32'(1));
        check("lat_t2_data", 32'(rsp_data), 32'(exp_val));
        check("lat_t2_id", 32'(rsp_id), 32'(idx));
        tick();
    endtask

    function automatic logic [11:0] pick();
        logic [11:0] v;
        case ($urandom_range(0, 5))
            0:       v = 12'h180;
            1:       v = 12'h181;
            2:       v = 12'h800;
            3:       v = 12'($urandom);
            default: v = {1'($urandom), 11'($urandom_range(0, 384))};
        endcase
        return v;
    endfunction

    initial begin
        logic [11:0] held_data;
        logic [1:0]  held_id;

        rst       = 1'b1;
        req_valid = 4'hF;
        repeat (3) tick();
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_rsp_data", 32'(rsp_data), 32'(0));
        check("reset_rsp_id", 32'(rsp_id), 32'(0));
        check("reset_no_grant", 32'(req_ready), 32'(0));
        check("reset_no_rom_en", 32'(rom_en), 32'(0));
        tick();
        rst       = 1'b0;
        req_valid = '0;
        tick();

        single(0, 12'h000, 12'h020, 9'd0);
        single(1, 12'h820, 12'h018, 9'd32);
        single(1, 12'h0C0, 12'h03F, 9'd192);
        single(2, 12'h200, 12'h040, 9'd0);
        single(3, 12'hA00, 12'h000, 9'd0);

        // Pointer is back at 0 after req3 was served.
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) req_data[i*12 +: 12] = 12'(i * 16);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) check("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                check("fair_rsp_valid", 32'(rsp_valid), 32'(1));
                check("fair_rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
            end
            tick();
            if (k == 7) req_valid = '0;
        end

        req_valid = 4'hF;
        repeat (3) tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        held_data = rsp_data;
        held_id   = rsp_id;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_no_grant", 32'(req_ready), 32'(0));
            check("bp_no_rom_en", 32'(rom_en), 32'(0));
            check("bp_hold_data", 32'(rsp_data), 32'(held_data));
            check("bp_hold_id", 32'(rsp_id), 32'(held_id));
            tick();
        end
        rsp_ready = 1'b1;
        repeat (4) tick();
        req_valid = '0;
        repeat (3) tick();

        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_flush_quiet", 32'(rsp_valid), 32'(0));
            tick();
        end
        req_valid = 4'hF;
        @(negedge clk);
        check("rst_ptr_zero", 32'(req_ready), 32'(1));
        tick();
        req_valid = '0;
        repeat (3) tick();

        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) req_data[i*12 +: 12] = pick();
            tick();
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) tick();
        check("drain_empty", 32'(q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sigmoid_lut_sched.md
Name: sigmoid_lut_sched

Overview:
- Shares one synchronous-read sigmoid LUT ROM among N_REQ requesters, e.g. the input, forget and output gate units of the LSTM cell.
- Uses round-robin arbitration and a valid/ready handshake on every requester port and on the response port.
- Instantiates the existing combinational sigmoid_addr_calc to turn the 12-bit sign-magnitude Q5.6 input into a 9-bit LUT address and an out-of-range flag.
- Applies sign symmetry, sigmoid(-x) = 1 - sigmoid(x), and saturation, then returns the result tagged with the requester ID.

Parameters:
- N_REQ, 4, number of requesters.
- ID_W, 2, width of the requester ID; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  N_REQ*12  per-requester operand; bit 11 is the sign, bits 10:0 are the magnitude in Q5.6. Requester i uses bits [12i+11:12i].
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- rom_en  out  1  ROM read enable.
- rom_addr  out  9  ROM address.
- rom_data  in  12  ROM read data, valid 1 cycle after rom_en. The ROM holds its output while rom_en=0.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_data  out  12  sigmoid result, unsigned Q5.6; 1.0 = 12'h040.
- rsp_id  out  ID_W  ID of the requester that produced the result.

Behaviour:
- Reset state: rsp_valid=0, rsp_data=0, rsp_id=0, s1_valid=0, round-robin pointer=0. rom_en=0 and req_ready=0 while rst=1.
- stall = rsp_valid & ~rsp_ready.
- Arbitration is combinational. When ~stall, grant goes to the first requester with req_valid set, searching from the pointer upward and wrapping at N_REQ. req_ready = grant. No grant is issued during stall or rst.
- Accept: a cycle t with req_valid[i] & req_ready[i].
  - rom_en=1 and rom_addr = addr_out of sigmoid_addr_calc driven by the winner's req_data.
  - Pointer <= (i+1) mod N_REQ.
  - Stage S1 registers: s1_valid=1, s1_sign, s1_oor, s1_id=i.
- With no accept and ~stall: s1_valid <= 0 and the pointer holds.
- Stage S2, cycle t+1, when s1_valid & ~stall, compute the result:
  - s1_oor and positive: 12'h040.
  - s1_oor and negative: 12'h000.
  - Positive, in range: rom_data.
  - Negative, in range: 12'h040 - rom_data.
  - Negative zero (12'h800) takes the negative path.
  - Register the result into rsp_data/rsp_id and set rsp_valid=1 at t+2.
- Latency: accept to rsp_valid is exactly 2 cycles. Throughput is 1 result per cycle while rsp_ready=1.
- rsp_valid clears on (rsp_valid & rsp_ready) when no new S2 result arrives. Back-to-back results keep rsp_valid=1.
- During stall:
  - S1, rsp_data and rsp_id hold.
  - rom_en=0, so the ROM output holds.
  - No grant is issued.
  - rsp_data and rsp_id must not change while rsp_valid=1 and rsp_ready=0.
- Out-of-range: the out_of_range flag of sigmoid_addr_calc sets exactly when the magnitude is greater than 6.0 (12'h180). During an out-of-range access rom_en is still asserted and rom_data is ignored.
- Simultaneous rsp handshake and new S2 result: the register loads the new result and rsp_valid stays 1.
- Reset asserted mid-operation: in-flight S1 and rsp contents are dropped, with no response, and the pointer returns to 0.
- Dropping req_valid while unserved is legal. req_data must stay stable only in the accept cycle.

Decomposition:
- Package sigmoid_pkg: DATA_W=12, FRAC_W=6, ADDR_W=9, SIG_ONE=12'h040, SIG_MAX_MAG=12'h180.
- Sub-module sigmoid_rr_arb(N_REQ): combinational one-hot grant from req_valid and pointer, plus pointer register update on accept.
- sigmoid_addr_calc is reused unchanged.

Test Plan:
- Bench ROM model: sync-read, lut[0]=12'h020, lut[32]=12'h028, lut[192]=12'h03F.
- Single requester: req0 sends 12'h000 at t → rom_addr=0 at t; rsp_valid at t+2 with rsp_data=12'h020, rsp_id=0.
- Negative input: req1 sends 12'h820 → rom_addr=32, rsp_data=12'h018 (64-40), rsp_id=1. Then req1 sends 12'h0C0 → rsp_data=12'h03F.
- Saturation: 12'h200 → rsp_data=12'h040; 12'hA00 → rsp_data=12'h000.
- Fairness: all 4 requesters hold valid for 8 cycles with rsp_ready=1 → grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order 2 cycles later, with one response per cycle.
- Backpressure: rsp_ready=0 for 3 cycles during the all-valid stream → req_ready=0, rom_en=0, rsp_data/rsp_id held. After release the sequence continues with no loss or duplication.
- Reset mid-flight: rst=1 for 1 cycle one cycle after an accept → no rsp_valid afterwards, pointer=0, and the next simultaneous request from all requesters grants req0.
